// File: rtl/idex_operand_stage_if.sv
// ID/EX operand stage bus: decode fields, forward sources and flush
// flow in; ALU operands, stall and registered controls flow out.
interface idex_operand_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_uses_rs1;
    logic            id_uses_rs2;
    logic [3:0]      id_alu_control;
    logic            id_use_pc;
    logic            id_use_imm;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            flush;
    logic [4:0]      exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [4:0]      memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_result;

    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] Arg1;
    logic [XLEN-1:0] Arg2;
    logic [3:0]      ALU_Control;
    logic [XLEN-1:0] ex_store_data;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
        input  id_alu_control, id_use_pc, id_use_imm,
        input  id_reg_write, id_mem_read, id_mem_write, flush,
        input  exmem_rd, exmem_reg_write, exmem_result,
        input  memwb_rd, memwb_reg_write, memwb_result,
        output stall, ex_valid, Arg1, Arg2, ALU_Control,
        output ex_store_data, ex_rd,
        output ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1, id_rs2, id_rd, id_uses_rs1, id_uses_rs2,
        output id_alu_control, id_use_pc, id_use_imm,
        output id_reg_write, id_mem_read, id_mem_write, flush,
        output exmem_rd, exmem_reg_write, exmem_result,
        output memwb_rd, memwb_reg_write, memwb_result,
        input  stall, ex_valid, Arg1, Arg2, ALU_Control,
        input  ex_store_data, ex_rd,
        input  ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX register and ALU operand select with forwarding and load-use stall.
// Ports: clk, rst (sync, active-high), bus (idex_operand_stage_if.slave).
module idex_operand_stage (
    input logic                 clk,
    input logic                 rst,
    idex_operand_stage_if.slave bus
);
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_control;
        logic            use_pc;
        logic            use_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } stage_t;

    stage_t          ex;
    logic            hz;
    logic [XLEN-1:0] rs1_cap;
    logic [XLEN-1:0] rs2_cap;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            wb_hit1;
    logic            wb_hit2;

    // Load in EX whose destination the decode instruction reads.
    assign hz = bus.id_valid && ex.valid && ex.mem_read
             && (ex.rd != 5'd0)
             && ((bus.id_uses_rs1 && (bus.id_rs1 == ex.rd))
              || (bus.id_uses_rs2 && (bus.id_rs2 == ex.rd)));

    // A flushed decode instruction is discarded, so holding it is moot.
    assign bus.stall = hz && !bus.flush;

    // Regfile write and read in the same cycle: take the value being written.
    assign wb_hit1 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0)
                  && (bus.memwb_rd == bus.id_rs1);
    assign wb_hit2 = bus.memwb_reg_write && (bus.memwb_rd != 5'd0)
                  && (bus.memwb_rd == bus.id_rs2);
    assign rs1_cap = wb_hit1 ? bus.memwb_result : bus.id_rs1_data;
    assign rs2_cap = wb_hit2 ? bus.memwb_result : bus.id_rs2_data;

    always_ff @(posedge clk) begin
        if (rst || bus.flush || hz) begin
            ex <= '0;
        end else begin
            ex.valid       <= bus.id_valid;
            ex.pc          <= bus.id_pc;
            ex.rs1_data    <= rs1_cap;
            ex.rs2_data    <= rs2_cap;
            ex.imm         <= bus.id_imm;
            ex.rs1         <= bus.id_rs1;
            ex.rs2         <= bus.id_rs2;
            ex.rd          <= bus.id_rd;
            ex.alu_control <= bus.id_alu_control;
            ex.use_pc      <= bus.id_use_pc;
            ex.use_imm     <= bus.id_use_imm;
            ex.reg_write   <= bus.id_reg_write;
            ex.mem_read    <= bus.id_mem_read;
            ex.mem_write   <= bus.id_mem_write;
        end
    end

    // The younger producer (EX/MEM) takes priority; x0 is never forwarded.
    always_comb begin
        fwd_rs1 = ex.rs1_data;
        if ((ex.rs1 != 5'd0) && bus.exmem_reg_write
            && (bus.exmem_rd == ex.rs1))
            fwd_rs1 = bus.exmem_result;
        else if ((ex.rs1 != 5'd0) && bus.memwb_reg_write
                 && (bus.memwb_rd == ex.rs1))
            fwd_rs1 = bus.memwb_result;
    end

    always_comb begin
        fwd_rs2 = ex.rs2_data;
        if ((ex.rs2 != 5'd0) && bus.exmem_reg_write
            && (bus.exmem_rd == ex.rs2))
            fwd_rs2 = bus.exmem_result;
        else if ((ex.rs2 != 5'd0) && bus.memwb_reg_write
                 && (bus.memwb_rd == ex.rs2))
            fwd_rs2 = bus.memwb_result;
    end

    assign bus.Arg1          = ex.use_pc  ? ex.pc  : fwd_rs1;
    assign bus.Arg2          = ex.use_imm ? ex.imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ALU_Control   = ex.alu_control;
    assign bus.ex_valid      = ex.valid;
    assign bus.ex_rd         = ex.rd;
    assign bus.ex_reg_write  = ex.reg_write;
    assign bus.ex_mem_read   = ex.mem_read;
    assign bus.ex_mem_write  = ex.mem_write;
endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, capture, forwarding,
// x0 guard, load-use stall, flush, write-through and reset mid-stall.
module tb_idex_operand_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    idex_operand_stage_if bus ();

    idex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.id_valid        = 1'b0;
        bus.id_pc           = '0;
        bus.id_rs1_data     = '0;
        bus.id_rs2_data     = '0;
        bus.id_imm          = '0;
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_rd           = '0;
        bus.id_uses_rs1     = 1'b0;
        bus.id_uses_rs2     = 1'b0;
        bus.id_alu_control  = '0;
        bus.id_use_pc       = 1'b0;
        bus.id_use_imm      = 1'b0;
        bus.id_reg_write    = 1'b0;
        bus.id_mem_read     = 1'b0;
        bus.id_mem_write    = 1'b0;
        bus.flush           = 1'b0;
        bus.exmem_rd        = '0;
        bus.exmem_reg_write = 1'b0;
        bus.exmem_result    = '0;
        bus.memwb_rd        = '0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_result    = '0;
    endtask

    // Puts "lw x3, 0(x1)" into the stage.
    task automatic load_lw();
        clear_inputs();
        bus.id_valid     = 1'b1;
        bus.id_rs1       = 5'd1;
        bus.id_uses_rs1  = 1'b1;
        bus.id_rd        = 5'd3;
        bus.id_use_imm   = 1'b1;
        bus.id_reg_write = 1'b1;
        bus.id_mem_read  = 1'b1;
        step();
    endtask

    // Decode "add x6, x1, x3" that depends on the load.
    task automatic decode_add();
        clear_inputs();
        bus.id_valid     = 1'b1;
        bus.id_rs1       = 5'd1;
        bus.id_rs2       = 5'd3;
        bus.id_uses_rs1  = 1'b1;
        bus.id_uses_rs2  = 1'b1;
        bus.id_rs1_data  = 32'h10;
        bus.id_rs2_data  = 32'h0;
        bus.id_rd        = 5'd6;
        bus.id_reg_write = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.id_valid     = 1'b1;
        bus.id_rs1_data  = 32'h1234;
        bus.id_reg_write = 1'b1;
        bus.id_alu_control = 4'h7;
        step();
        step();
        chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_arg1", bus.Arg1, 32'd0);
        chk("rst_arg2", bus.Arg2, 32'd0);
        chk("rst_aluc", 32'(bus.ALU_Control), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_regw", 32'(bus.ex_reg_write), 32'd0);
        chk("rst_store", bus.ex_store_data, 32'd0);
        rst = 1'b0;
    endtask

    task automatic test_capture();
        clear_inputs();
        bus.id_valid       = 1'b1;
        bus.id_pc          = 32'h100;
        bus.id_rs1_data    = 32'hA;
        bus.id_rs2_data    = 32'hB;
        bus.id_imm         = 32'h4;
        bus.id_rs1         = 5'd1;
        bus.id_rs2         = 5'd2;
        bus.id_rd          = 5'd4;
        bus.id_alu_control = 4'h5;
        bus.id_reg_write   = 1'b1;
        bus.id_mem_write   = 1'b1;
        step();
        chk("cap_valid", 32'(bus.ex_valid), 32'd1);
        chk("cap_arg1", bus.Arg1, 32'hA);
        chk("cap_arg2", bus.Arg2, 32'hB);
        chk("cap_aluc", 32'(bus.ALU_Control), 32'h5);
        chk("cap_rd", 32'(bus.ex_rd), 32'd4);
        chk("cap_regw", 32'(bus.ex_reg_write), 32'd1);
        chk("cap_memw", 32'(bus.ex_mem_write), 32'd1);
        bus.id_use_pc  = 1'b1;
        bus.id_use_imm = 1'b1;
        step();
        chk("sel_arg1_pc", bus.Arg1, 32'h100);
        chk("sel_arg2_imm", bus.Arg2, 32'h4);
        chk("sel_store", bus.ex_store_data, 32'hB);
        bus.exmem_rd        = 5'd2;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_result    = 32'hCAFE;
        #1;
        chk("store_fwd", bus.ex_store_data, 32'hCAFE);
        chk("store_fwd_arg2", bus.Arg2, 32'h4);
    endtask

    task automatic test_dual_forward();
        clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_rs1      = 5'd5;
        bus.id_rs1_data = 32'h55;
        step();
        bus.id_valid        = 1'b0;
        bus.exmem_rd        = 5'd5;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_result    = 32'h11;
        bus.memwb_rd        = 5'd5;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'h22;
        #1;
        chk("fwd_exmem_wins", bus.Arg1, 32'h11);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_memwb", bus.Arg1, 32'h22);
        bus.memwb_reg_write = 1'b0;
        #1;
        chk("fwd_none", bus.Arg1, 32'h55);
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        bus.id_valid = 1'b1;
        step();
        bus.exmem_rd        = 5'd0;
        bus.exmem_reg_write = 1'b1;
        bus.exmem_result    = 32'hDEADBEEF;
        bus.memwb_rd        = 5'd0;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'hBAD0BAD0;
        #1;
        chk("x0_arg2", bus.Arg2, 32'd0);
        chk("x0_store", bus.ex_store_data, 32'd0);
        chk("x0_arg1", bus.Arg1, 32'd0);
    endtask

    task automatic test_load_use();
        load_lw();
        chk("lu_ld_mr", 32'(bus.ex_mem_read), 32'd1);
        decode_add();
        chk("lu_stall", 32'(bus.stall), 32'd1);
        step();
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        chk("lu_bub_mr", 32'(bus.ex_mem_read), 32'd0);
        chk("lu_bub_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("lu_stall_off", 32'(bus.stall), 32'd0);
        step();
        bus.id_valid        = 1'b0;
        bus.memwb_rd        = 5'd3;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'h77;
        #1;
        chk("lu_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_add_rd", 32'(bus.ex_rd), 32'd6);
        chk("lu_add_arg1", bus.Arg1, 32'h10);
        chk("lu_add_arg2", bus.Arg2, 32'h77);
        chk("lu_add_stall", 32'(bus.stall), 32'd0);
    endtask

    task automatic test_flush_vs_hazard();
        load_lw();
        decode_add();
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", 32'(bus.stall), 32'd0);
        step();
        bus.flush = 1'b0;
        chk("fl_valid", 32'(bus.ex_valid), 32'd0);
        chk("fl_rd", 32'(bus.ex_rd), 32'd0);
        chk("fl_regw", 32'(bus.ex_reg_write), 32'd0);
    endtask

    task automatic test_write_through();
        clear_inputs();
        bus.id_valid        = 1'b1;
        bus.id_rs1          = 5'd7;
        bus.id_rs1_data     = 32'h5;
        bus.memwb_rd        = 5'd7;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'h99;
        step();
        bus.id_valid        = 1'b0;
        bus.memwb_reg_write = 1'b0;
        #1;
        chk("wt_arg1", bus.Arg1, 32'h99);
        clear_inputs();
        bus.id_valid        = 1'b1;
        bus.id_rs2          = 5'd7;
        bus.id_rs2_data     = 32'h6;
        bus.memwb_rd        = 5'd8;
        bus.memwb_reg_write = 1'b1;
        bus.memwb_result    = 32'h99;
        step();
        bus.memwb_reg_write = 1'b0;
        #1;
        chk("wt_miss_arg2", bus.Arg2, 32'h6);
    endtask

    task automatic test_rst_mid_stall();
        load_lw();
        decode_add();
        chk("rs_stall_on", 32'(bus.stall), 32'd1);
        rst = 1'b1;
        step();
        chk("rs_valid", 32'(bus.ex_valid), 32'd0);
        chk("rs_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_capture();
        test_dual_forward();
        test_x0_guard();
        test_load_use();
        test_flush_vs_hazard();
        test_write_through();
        test_rst_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the RV32 ALU. It registers decoded instruction fields and drives the ALU's Arg1, Arg2 and ALU_Control inputs. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and by inserting a one-cycle bubble on load-use. It also honours pipeline flush from branch/jump resolution.

## Interface
- XLEN, 32, datapath width (fixed 32 for RV32I)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  decode holds a valid instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  decode-stage values
- id_rs1, id_rs2, id_rd  in  5 each  register addresses
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads the register
- id_alu_control  in  4  ALU operation code, passed to ALU_Control unchanged
- id_use_pc, id_use_imm  in  1 each  Arg1 = PC / Arg2 = immediate select
- id_reg_write, id_mem_read, id_mem_write  in  1 each  control for later stages
- flush  in  1  kill the instruction entering this stage
- exmem_rd  in  5 / exmem_reg_write  in  1 / exmem_result  in  32  EX/MEM forward source
- memwb_rd  in  5 / memwb_reg_write  in  1 / memwb_result  in  32  MEM/WB forward source (also the regfile write port)
- stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  stage holds a valid instruction
- Arg1, Arg2  out  32 each  ALU operands
- ALU_Control  out  4  ALU operation
- ex_store_data  out  32  forwarded rs2 value for stores
- ex_rd  out  5 / ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  registered controls

## Operation
- Stage register holds: valid, pc, rs1/rs2 data, imm, rs1/rs2/rd addresses, alu_control, use_pc, use_imm, reg_write, mem_read, mem_write.
- Load-use hazard is `hz = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
- Stall is `stall = hz & ~flush`. Flush kills the decode instruction, so no stall is needed.
- Per-edge update, in priority order:
  - rst: load bubble.
  - flush: load bubble.
  - hz: load bubble.
  - otherwise: load decode fields, with valid = id_valid.
- Bubble: valid = 0, reg_write = mem_read = mem_write = 0, alu_control = 4'b0000, every data/address field = 0.
- Capture-time write-through: if memwb_reg_write & memwb_rd != 0 & memwb_rd == id_rs1, capture memwb_result as rs1 data. rs2 is handled the same way. This covers regfile write and read in the same cycle.
- Execute-time forwarding is combinational from the stage registers, computed per operand. rs1 rule:
  - if ex_rs1 != 0 & exmem_reg_write & exmem_rd == ex_rs1: use exmem_result;
  - else if ex_rs1 != 0 & memwb_reg_write & memwb_rd == ex_rs1: use memwb_result;
  - else: use the registered rs1 data.
  - EX/MEM always wins over MEM/WB.
  - x0 is never forwarded.
- Arg1 = use_pc ? pc : fwd_rs1.
- Arg2 = use_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2, always forwarded even when use_imm = 1.
- ALU_Control, ex_rd and the ex_* control outputs come straight from the registers.
- ex_reg_write, ex_mem_read and ex_mem_write are 0 whenever valid = 0, which the bubble guarantees.

## Timing
- Reset values:
  - ex_valid = 0, ALU_Control = 0, ex_rd = 0, every ex_* control = 0.
  - Arg1 = Arg2 = ex_store_data = 0, because the registers are 0 and x0 is not forwarded.
  - stall = 0, because ex_valid = 0.
- Latency: decode fields appear on the outputs 1 cycle after capture. Forwarding adds no cycles; it is same-cycle combinational.
- Load-use handling:
  - Stall lasts exactly 1 cycle, because the bubble clears ex_mem_read on the next edge.
  - The following cycle captures the held decode instruction.
  - The load result then arrives via the MEM/WB forward.
- Upstream contract: while stall = 1, IF/ID must hold its decode outputs stable.
- flush with hz in the same cycle: bubble loaded, stall = 0.
- rst asserted mid-stall: bubble loaded, stall drops the same cycle rst clears ex_valid.

## Test plan
- Reset: hold rst for 2 cycles with id_valid = 1 → ex_valid = 0, Arg1 = Arg2 = 0, ALU_Control = 0, stall = 0.
- Dual forward:
  - Stimulus: ex_rs1 = 5, exmem_rd = 5 with exmem_result = 0x11, memwb_rd = 5 with memwb_result = 0x22, both write enables = 1, use_pc = 0.
  - Required: Arg1 = 0x11.
  - Then drop exmem_reg_write → Arg1 = 0x22.
- x0 guard: ex_rs2 = 0, exmem_rd = 0, exmem_reg_write = 1, exmem_result = 0xDEADBEEF, registered rs2 data = 0 → Arg2 = 0, ex_store_data = 0.
- Load-use:
  - Stimulus: lw x3 in stage (mem_read = 1, rd = 3); decode add with rs2 = 3.
  - Required: stall = 1 for one cycle, then a bubble with ex_valid = 0.
  - Next edge: the add is captured and stall = 0.
- Flush vs hazard: same setup as load-use with flush = 1 → stall = 0, next ex_valid = 0.
- Write-through: id_rs1 = 7, id_rs1_data = 0x5, memwb_rd = 7, memwb_reg_write = 1, memwb_result = 0x99 at the capture edge → Arg1 = 0x99 next cycle, with no forward sources active.
